// File: rtl/block_shader_pipe.sv
// rtl/block_shader_pipe.sv - bevelled Tetris cell shader with line-clear flash sequencer; optional ghost shading under SHADER_GHOST_EN
module block_shader_pipe #(
   parameter int CELL_W        = 26,
   parameter int CELL_H        = 32,
   parameter int COORD_W       = 6,
   parameter int EDGE          = 2,
   parameter int BEVEL         = 4,
   parameter int CH_W          = 4,
   parameter int FLASH_FRAMES  = 8,
   parameter int FLASH_TOGGLES = 6
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef SHADER_GHOST_EN
   input  logic                 ghost,
`endif
   input  logic                 pix_valid,
   input  logic [COORD_W-1:0]   block_x,
   input  logic [COORD_W-1:0]   block_y,
   input  logic [3*CH_W-1:0]    in_color,
   input  logic                 cell_clear,
   input  logic                 frame_tick,
   input  logic                 flash_start,
   output logic                 out_valid,
   output logic [3*CH_W-1:0]    out_color,
   output logic                 flash_busy,
   output logic                 flash_done
);

   localparam int PW  = 2*COORD_W + 1;
   localparam int CW  = 3*CH_W;
   localparam int FRW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam int PHW = $clog2(FLASH_TOGGLES);

   localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(CELL_W);
   localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(CELL_H);
   localparam logic [COORD_W-1:0] E_LO     = COORD_W'(EDGE);
   localparam logic [COORD_W-1:0] X_E_HI   = COORD_W'(CELL_W - EDGE);
   localparam logic [COORD_W-1:0] Y_E_HI   = COORD_W'(CELL_H - EDGE);
   localparam logic [COORD_W-1:0] B_LO     = COORD_W'(BEVEL);
   localparam logic [COORD_W-1:0] X_B_HI   = COORD_W'(CELL_W - BEVEL);
   localparam logic [COORD_W-1:0] Y_B_HI   = COORD_W'(CELL_H - BEVEL);
   localparam logic [FRW-1:0]     FRAME_LAST = FRW'(FLASH_FRAMES - 1);
   localparam logic [PHW-1:0]     PHASE_LAST = PHW'(FLASH_TOGGLES - 1);

   // per-channel masks: dull keeps the top two bits, super-dull the top bit
   localparam logic [CH_W-1:0] CH_DULL  = {2'b11, {(CH_W-2){1'b0}}};
   localparam logic [CH_W-1:0] CH_SDULL = {1'b1, {(CH_W-1){1'b0}}};
   localparam logic [CW-1:0]   M_DULL   = {3{CH_DULL}};
   localparam logic [CW-1:0]   M_SDULL  = {3{CH_SDULL}};
   localparam logic [CW-1:0]   C_ONES   = {CW{1'b1}};

   // RANGE encodes as zero so a reset stage-1 register shades to black
   typedef enum logic [2:0] {
      RG_RANGE  = 3'd0,
      RG_EDGE   = 3'd1,
      RG_CENTER = 3'd2,
      RG_TOP    = 3'd3,
      RG_BOT    = 3'd4
   } region_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_DONE = 2'd3
   } flash_t;

   flash_t          r_state, w_state_nx;
   logic [FRW-1:0]  r_frame_cnt, w_frame_nx;
   logic [PHW-1:0]  r_phase_cnt, w_phase_nx;

   logic [PW-1:0]   w_px, w_py;
   region_t         w_region;

   logic            r1_valid, r1_clear;
   logic [CW-1:0]   r1_color;
   region_t         r1_region;
`ifdef SHADER_GHOST_EN
   logic            r1_ghost;
`endif

   logic            r2_valid;
   logic [CW-1:0]   r2_color;
   logic [CW-1:0]   w_shade;

   // diagonal split: compare x/CELL_W against y/CELL_H without division
   assign w_px = PW'(block_x) * PW'(CELL_H);
   assign w_py = PW'(block_y) * PW'(CELL_W);

   // classify the pixel into its bevel region, first match wins
   always_comb begin
      w_region = RG_BOT;
      if (block_x >= X_LIM || block_y >= Y_LIM)
         w_region = RG_RANGE;
      else if (block_x < E_LO || block_x >= X_E_HI || block_y < E_LO || block_y >= Y_E_HI)
         w_region = RG_EDGE;
      else if (block_x >= B_LO && block_x < X_B_HI && block_y >= B_LO && block_y < Y_B_HI)
         w_region = RG_CENTER;
      else if (w_px > w_py)
         w_region = RG_TOP;
   end

   // stage 1: register colour, clear flag and region class
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid  <= 1'b0;
         r1_clear  <= 1'b0;
         r1_color  <= '0;
         r1_region <= RG_RANGE;
`ifdef SHADER_GHOST_EN
         r1_ghost  <= 1'b0;
`endif
      end else begin
         r1_valid  <= pix_valid;
         r1_clear  <= cell_clear;
         r1_color  <= in_color;
         r1_region <= w_region;
`ifdef SHADER_GHOST_EN
         r1_ghost  <= ghost;
`endif
      end
   end

   // stage-2 colour: region shading, then the flash override for clearing rows
   always_comb begin
      w_shade = '0;
      case (r1_region)
         RG_RANGE:  w_shade = '0;
         RG_EDGE:   w_shade = C_ONES;
         RG_CENTER: w_shade = r1_color & M_DULL;
         RG_TOP:    w_shade = r1_color;
         RG_BOT:    w_shade = r1_color & M_SDULL;
         default:   w_shade = '0;
      endcase
`ifdef SHADER_GHOST_EN
      if (r1_ghost) begin
         case (r1_region)
            RG_EDGE:        w_shade = r1_color & M_SDULL;
            RG_CENTER:      w_shade = '0;
            RG_TOP, RG_BOT: w_shade = r1_color & M_DULL;
            default:        w_shade = '0;
         endcase
      end
`endif
      if (r1_clear) begin
         if (r_state == S_ON)
            w_shade = C_ONES;
         else if (r_state == S_OFF)
            w_shade = '0;
      end
   end

   // stage 2: output register, colour refreshed every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r2_valid <= 1'b0;
         r2_color <= '0;
      end else begin
         r2_valid <= r1_valid;
         r2_color <= w_shade;
      end
   end

   assign out_valid = r2_valid;
   assign out_color = r2_color;

   // flash sequencer state and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_frame_cnt <= '0;
         r_phase_cnt <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_frame_cnt <= w_frame_nx;
         r_phase_cnt <= w_phase_nx;
      end
   end

   // flash next-state: count ticks per phase, toggle ON/OFF, finish after the last phase
   always_comb begin
      w_state_nx = r_state;
      w_frame_nx = r_frame_cnt;
      w_phase_nx = r_phase_cnt;
      flash_busy = 1'b0;
      flash_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (flash_start) begin
               w_state_nx = S_ON;
               w_frame_nx = '0;
               w_phase_nx = '0;
            end
         end
         S_ON, S_OFF: begin
            flash_busy = 1'b1;
            if (frame_tick) begin
               if (r_frame_cnt == FRAME_LAST) begin
                  w_frame_nx = '0;
                  w_phase_nx = r_phase_cnt + PHW'(1);
                  if (r_phase_cnt == PHASE_LAST)
                     w_state_nx = S_DONE;
                  else
                     w_state_nx = (r_state == S_ON) ? S_OFF : S_ON;
               end else begin
                  w_frame_nx = r_frame_cnt + FRW'(1);
               end
            end
         end
         S_DONE: begin
            flash_busy = 1'b1;
            flash_done = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_block_shader_pipe.sv
// tb/tb_block_shader_pipe.sv - directed self-checking bench for block_shader_pipe
module tb_block_shader_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid;
   logic [5:0]  block_x, block_y;
   logic [11:0] in_color;
   logic        cell_clear, frame_tick, flash_start;
   logic        out_valid, flash_busy, flash_done;
   logic [11:0] out_color;
`ifdef SHADER_GHOST_EN
   logic        ghost;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   block_shader_pipe #(
      .FLASH_FRAMES  (2),
      .FLASH_TOGGLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef SHADER_GHOST_EN
      .ghost       (ghost),
`endif
      .pix_valid   (pix_valid),
      .block_x     (block_x),
      .block_y     (block_y),
      .in_color    (in_color),
      .cell_clear  (cell_clear),
      .frame_tick  (frame_tick),
      .flash_start (flash_start),
      .out_valid   (out_valid),
      .out_color   (out_color),
      .flash_busy  (flash_busy),
      .flash_done  (flash_done)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      steps(3);
   endtask

   int          sx[5]  = '{0, 10, 20, 3, 30};
   int          sy[5]  = '{5, 10, 3, 20, 4};
   logic [11:0] sc[5]  = '{12'hFFF, 12'hC84, 12'hF84, 12'h880, 12'h000};
   logic        gp[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      rst = 1'b1; pix_valid = 1'b1; block_x = 6'd0; block_y = 6'd5;
      in_color = 12'hF84; cell_clear = 1'b0; frame_tick = 1'b0; flash_start = 1'b0;
`ifdef SHADER_GHOST_EN
      ghost = 1'b0;
`endif
      // reset held three cycles with a valid pixel on the input
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_valid", out_valid, 0);
         check("rst_color", out_color, 12'h000);
         check("rst_busy", flash_busy, 0);
      end
      rst = 1'b0;
      step();
      check("post_rst_valid", out_valid, 0);
      check("post_rst_color", out_color, 12'h000);
      check("post_rst_busy", flash_busy, 0);
      pix_valid = 1'b0;
      steps(3);

      // back-to-back region stream
      for (int i = 0; i < 7; i++) begin
         if (i < 5) begin
            pix_valid = 1'b1; block_x = 6'(sx[i]); block_y = 6'(sy[i]);
         end else begin
            pix_valid = 1'b0;
         end
         step();
         if (i >= 1 && i <= 5) begin
            check($sformatf("stream_valid%0d", i-1), out_valid, 1);
            check($sformatf("stream_color%0d", i-1), out_color, sc[i-1]);
         end else if (i == 6) begin
            check("stream_tail_valid", out_valid, 0);
         end
      end

      // valid gaps
      block_x = 6'd10; block_y = 6'd10;
      for (int i = 0; i < 7; i++) begin
         pix_valid = (i < 5) ? gp[i] : 1'b0;
         step();
         if (i >= 1) check($sformatf("gap_valid%0d", i-1), out_valid, (i-1 < 5) ? 32'(gp[i-1]) : 0);
      end

      // flash sequence, steady clearing pixel at (10,10)
      pix_valid = 1'b1; cell_clear = 1'b1;
      tick();
      check("idle_tick_busy", flash_busy, 0);
      check("idle_color", out_color, 12'hC84);
      flash_start = 1'b1;
      step();
      flash_start = 1'b0;
      check("start_busy", flash_busy, 1);
      steps(2);
      check("on0_color", out_color, 12'hFFF);
      cell_clear = 1'b0; steps(2);
      check("on0_noclear", out_color, 12'hC84);
      cell_clear = 1'b1; steps(2);
      tick();
      flash_start = 1'b1; step(); flash_start = 1'b0;
      tick();
      check("off1_color", out_color, 12'h000);
      check("off1_busy", flash_busy, 1);
      cell_clear = 1'b0; steps(2);
      check("off1_noclear", out_color, 12'hC84);
      cell_clear = 1'b1; steps(2);
      tick(); tick();
      check("on2_color", out_color, 12'hFFF);
      tick(); tick();
      check("off3_color", out_color, 12'h000);
      tick();
      check("tick7_busy", flash_busy, 1);
      check("tick7_done", flash_done, 0);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      check("done_pulse", flash_done, 1);
      check("done_busy", flash_busy, 1);
      step();
      check("done_gone", flash_done, 0);
      check("idle_busy", flash_busy, 0);
      steps(2);
      check("after_color", out_color, 12'hC84);

      // reset in the middle of a sequence
      flash_start = 1'b1; step(); flash_start = 1'b0;
      tick(); tick(); tick();
      check("mid_busy", flash_busy, 1);
      rst = 1'b1; step();
      check("abort_busy", flash_busy, 0);
      check("abort_done", flash_done, 0);
      check("abort_valid", out_valid, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         frame_tick = (i % 2 == 0);
         step();
         check("abort_no_done", flash_done, 0);
         check("abort_idle", flash_busy, 0);
      end
      frame_tick = 1'b0;
      steps(2);
      check("abort_color", out_color, 12'hC84);
      cell_clear = 1'b0;

`ifdef SHADER_GHOST_EN
      ghost = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pix_valid = (i < 3);
         case (i)
            0: begin block_x = 6'd10; block_y = 6'd10; end
            1: begin block_x = 6'd0;  block_y = 6'd5;  end
            default: begin block_x = 6'd20; block_y = 6'd3; end
         endcase
         step();
         if (i >= 1) check($sformatf("ghost%0d", i), out_color,
                           (i == 1) ? 12'h000 : (i == 2) ? 12'h880 : 12'hC84);
      end
      step();
      check("ghost2", out_color, 12'hC84);
      ghost = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
